perf_event_counter_bank: RTL and testbench
==========================================

// Module: perf_event_counter_bank
// PURPOSE
// - Synthesizable performance-monitor bank for the pipelined processor: one free-running cycle counter plus
//   NUM_EVT event counters (retire, I/D-cache req/hit, etc.).
// - Counters freeze on halt; a 1-cycle-latency read port exposes the frozen values to the host.
// - Instantiated beside proc next to the MEM/WB stage; event strobes come from fetch, memory and memwb.
// PARAMETERS
// - NUM_EVT  default 6   number of event counters (1..15)
// - CNT_W    default 32  width of each counter, cycle counter included (8..64)
// - SEL_W    default 4   read-select width; must hold NUM_EVT (index 0 = cycle count)
// PORTS
// - clk       in   1                clock, all state on posedge
// - rst       in   1                asynchronous, active-low reset
// - en        in   1                counting enable
// - evt       in   NUM_EVT          per-cycle event strobes; bit i increments counter i+1
// - halt      in   1                processor halt strobe (halt_MW)
// - clear     in   1                synchronous clear of all counters and flags
// - rd_req    in   1                read request
// - rd_sel    in   SEL_W            0 = cycles, 1..NUM_EVT = events
// - rd_valid  out  1                read data valid, one cycle after rd_req
// - rd_data   out  CNT_W            read data
// - rd_err    out  1                with rd_valid: rd_sel was out of range
// - frozen    out  1                high in FROZEN
// - done      out  1                one-cycle pulse on entry to FROZEN
// - ovf       out  NUM_EVT+1        sticky per-counter wrap/saturate flags (bit 0 = cycles)
// BEHAVIOUR
// - Reset: all counters 0, state IDLE, outputs 0 (rd_valid, rd_data, rd_err, frozen, done, ovf).
// - FSM:
//   - IDLE   -> COUNT on en=1.
//   - COUNT  -> IDLE on en=0 (counters hold); -> FROZEN on halt=1.
//   - FROZEN -> IDLE on clear=1; en is ignored in FROZEN.
// - In COUNT:
//   - Cycle counter +1 every cycle.
//   - Counter i+1 increments by 1 when evt[i]=1.
//   - Strobes in the halt cycle itself are counted; FROZEN takes effect next cycle.
// - Priority clear > halt > en:
//   - clear zeroes all counters and ovf and drops same-cycle events.
//   - State goes to IDLE; halt in the same cycle is ignored.
// - Arithmetic: modulo 2^CNT_W; all-ones +1 wraps to 0 and sets the matching ovf bit (sticky until clear/reset).
// - done: asserted exactly in the first FROZEN cycle.
// - Read port:
//   - rd_req sampled at posedge N; rd_valid=1 in cycle N+1 only.
//   - rd_data = value held at edge N (pre-update); a read in a clear cycle returns the pre-clear value.
//   - rd_sel > NUM_EVT: rd_data=0, rd_err=1.
//   - Reads are legal in any state and back-to-back, one per cycle.
//   - rd_data holds its last value while rd_valid=0.
// - Reset mid-operation: immediate asynchronous return to reset values; a pending read is dropped (no rd_valid).
// CONFIGURATION
// - PERF_SAT_EN defined: counters saturate at all-ones instead of wrapping; ovf bit set on the first saturated
//   increment.
// - PERF_SAT_EN undefined: wrap-around behaviour as above.
// TESTING
// - en=1 for 10 cycles, evt[0] high 4 of them, halt on cycle 10 -> frozen=1 at cycle 11, done one pulse;
//   rd_sel=0 -> 10, rd_sel=1 -> 4.
// - In FROZEN, toggle evt and en for 20 cycles, then read all -> values unchanged; clear -> all read 0, state IDLE.
// - CNT_W=8, evt[1] high for 257 cycles:
//   - without PERF_SAT_EN -> counter2=1, ovf[2]=1
//   - with PERF_SAT_EN -> counter2=255, ovf[2]=1
// - clear, halt and evt[0] asserted in the same cycle -> counters 0, ovf 0, state IDLE, no done pulse.
// - rd_req with rd_sel=NUM_EVT+1 -> rd_valid=1, rd_err=1, rd_data=0 next cycle; back-to-back rd_sel 0,1,2 ->
//   three consecutive valid cycles in order.
// - Drop rst low in the cycle after rd_req in COUNT -> no rd_valid, all counters 0, state IDLE after release.

Source files
------------

// File: rtl/perf_event_counter_bank.sv
// Performance-monitor bank: free-running cycle counter plus NUM_EVT event counters, frozen on halt
// and read back through a 1-cycle-latency port. Define PERF_SAT_EN to saturate instead of wrapping.
module perf_event_counter_bank #(
    parameter int unsigned NUM_EVT = 6,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned SEL_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic               clear,
    input  logic               rd_req,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_err,
    output logic               frozen,
    output logic               done,
    output logic [NUM_EVT:0]   ovf
);

    localparam int unsigned NUM_CNT = NUM_EVT + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        FROZEN = 2'd2
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] incReq;
    logic [CNT_W-1:0]   rdMux;
    logic               selInRange;

    // Next state: clear beats halt, halt beats en
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (en) nextState = COUNT;
            COUNT: begin
                if (halt)     nextState = FROZEN;
                else if (!en) nextState = IDLE;
            end
            FROZEN:  nextState = FROZEN;
            default: nextState = IDLE;
        endcase
        if (clear) nextState = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            frozen <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nextState;
            frozen <= (nextState == FROZEN);
            done   <= (nextState == FROZEN) && (state != FROZEN);
        end
    end

    // Index 0 is the cycle counter, which ticks on every counting cycle
    always_comb begin
        incReq = {evt, 1'b1} & {NUM_CNT{(state == COUNT) && !clear}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clear) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (incReq[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
`ifdef PERF_SAT_EN
                        cnt[i] <= cnt[i];
`else
                        cnt[i] <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read mux sees pre-update values, so a read in a clear cycle returns pre-clear data
    always_comb begin
        rdMux      = '0;
        selInRange = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdMux      = cnt[i];
                selInRange = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else if (rd_req) begin
            rd_valid <= 1'b1;
            rd_data  <= rdMux;
            rd_err   <= !selInRange;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Bench for perf_event_counter_bank (CNT_W=8): count-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_perf_event_counter_bank;

    localparam int unsigned NUM_EVT = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned NUM_CNT = NUM_EVT + 1;
    localparam longint      CNT_MOD = longint'(1) << CNT_W;
    localparam int          M_IDLE   = 0;
    localparam int          M_COUNT  = 1;
    localparam int          M_FROZEN = 2;

    logic               clk;
    logic               rst;
    logic               en;
    logic [NUM_EVT-1:0] evt;
    logic               halt;
    logic               clear;
    logic               rd_req;
    logic [SEL_W-1:0]   rd_sel;
    logic               rd_valid;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_err;
    logic               frozen;
    logic               done;
    logic [NUM_EVT:0]   ovf;

    perf_event_counter_bank #(
        .NUM_EVT(NUM_EVT),
        .CNT_W  (CNT_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .evt     (evt),
        .halt    (halt),
        .clear   (clear),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .frozen  (frozen),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: true (unbounded) event counts; wrap/saturate applied only when reading out
    longint mCnt [NUM_CNT];
    int     mState;
    bit     mRdValid;
    longint mRdData;
    bit     mRdErr;
    bit     mFrozen;
    bit     mDone;
    bit     wasFrozen;
    int     sel;

    function automatic longint expVal(input longint c);
`ifdef PERF_SAT_EN
        return (c >= CNT_MOD) ? (CNT_MOD - 1) : c;
`else
        return c % CNT_MOD;
`endif
    endfunction

    function automatic longint expOvf();
        longint v = 0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (mCnt[i] >= CNT_MOD) v = v | (longint'(1) << i);
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) mCnt[i] = 0;
            mState   = M_IDLE;
            mRdValid = 1'b0;
            mRdData  = 0;
            mRdErr   = 1'b0;
            mFrozen  = 1'b0;
            mDone    = 1'b0;
        end else begin
            wasFrozen = (mState == M_FROZEN);
            sel = int'(rd_sel);
            if (rd_req) begin
                mRdValid = 1'b1;
                if (sel <= int'(NUM_EVT)) begin
                    mRdData = expVal(mCnt[sel]);
                    mRdErr  = 1'b0;
                end else begin
                    mRdData = 0;
                    mRdErr  = 1'b1;
                end
            end else begin
                mRdValid = 1'b0;
                mRdErr   = 1'b0;
            end
            if (clear) begin
                for (int i = 0; i < NUM_CNT; i++) mCnt[i] = 0;
                mState = M_IDLE;
            end else if (mState == M_IDLE) begin
                if (en) mState = M_COUNT;
            end else if (mState == M_COUNT) begin
                mCnt[0] = mCnt[0] + 1;
                for (int i = 0; i < int'(NUM_EVT); i++) begin
                    if (evt[i]) mCnt[i+1] = mCnt[i+1] + 1;
                end
                if (halt)     mState = M_FROZEN;
                else if (!en) mState = M_IDLE;
            end
            mFrozen = (mState == M_FROZEN);
            mDone   = mFrozen && !wasFrozen;
        end
    end

    task automatic checkEq(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readLit(input int s, input longint expData, input bit expErr, input string name);
        rd_req = 1'b1;
        rd_sel = SEL_W'(s);
        tick();
        rd_req = 1'b0;
        checkEq({name, " valid"}, longint'(rd_valid), 1);
        checkEq({name, " data"}, longint'(rd_data), expData);
        checkEq({name, " err"}, longint'(rd_err), longint'(expErr));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint frz [NUM_CNT];
        frz = '{10, 4, 0, 0, 0, 0, 0};
        rst = 1'b0; en = 1'b0; evt = '0; halt = 1'b0; clear = 1'b0;
        rd_req = 1'b0; rd_sel = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    checkEq("cyc rd_valid", longint'(rd_valid), longint'(mRdValid));
                    checkEq("cyc rd_err", longint'(rd_err), longint'(mRdErr));
                    checkEq("cyc rd_data", longint'(rd_data), mRdData);
                    checkEq("cyc frozen", longint'(frozen), longint'(mFrozen));
                    checkEq("cyc done", longint'(done), longint'(mDone));
                    checkEq("cyc ovf", longint'(ovf), expOvf());
                end
            end
        join_none

        // Reset values
        tick();
        checkEq("reset rd_valid", longint'(rd_valid), 0);
        checkEq("reset rd_data", longint'(rd_data), 0);
        checkEq("reset rd_err", longint'(rd_err), 0);
        checkEq("reset frozen", longint'(frozen), 0);
        checkEq("reset done", longint'(done), 0);
        checkEq("reset ovf", longint'(ovf), 0);
        rst = 1'b1;
        tick();

        // 10 counting cycles, evt[0] on 4 of them, halt on the 10th
        en = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            evt[0] = (c <= 8) && (c % 2 == 0);
            halt   = (c == 10);
            tick();
        end
        evt = '0; halt = 1'b0; en = 1'b0;
        checkEq("halt frozen", longint'(frozen), 1);
        checkEq("halt done", longint'(done), 1);
        tick();
        checkEq("done one pulse", longint'(done), 0);
        checkEq("still frozen", longint'(frozen), 1);
        readLit(0, 10, 1'b0, "rd cycles");
        readLit(1, 4, 1'b0, "rd evt0");

        // FROZEN ignores evt and en
        for (int c = 0; c < 20; c++) begin
            evt = NUM_EVT'(c * 11);
            en  = (c % 2) == 1;
            tick();
        end
        evt = '0; en = 1'b0;

        // Back-to-back read of every counter
        rd_req = 1'b1;
        for (int s = 0; s < int'(NUM_CNT); s++) begin
            rd_sel = SEL_W'(s);
            tick();
            checkEq("b2b valid", longint'(rd_valid), 1);
            checkEq("b2b data", longint'(rd_data), frz[s]);
        end
        rd_req = 1'b0;
        readLit(NUM_EVT + 1, 0, 1'b1, "rd oor7");
        readLit(15, 0, 1'b1, "rd oor15");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkEq("clear frozen", longint'(frozen), 0);
        for (int s = 0; s < int'(NUM_CNT); s++) readLit(s, 0, 1'b0, "rd after clear");

        // evt[1] for 257 counting cycles, halted on the last
        en = 1'b1;
        tick();
        for (int c = 1; c <= 257; c++) begin
            evt[1] = 1'b1;
            halt   = (c == 257);
            tick();
        end
        evt = '0; halt = 1'b0; en = 1'b0;
        checkEq("ovf 257", longint'(ovf), 5);
`ifdef PERF_SAT_EN
        readLit(2, 255, 1'b0, "rd evt1 sat");
        readLit(0, 255, 1'b0, "rd cycles sat");
`else
        readLit(2, 1, 1'b0, "rd evt1 wrap");
        readLit(0, 1, 1'b0, "rd cycles wrap");
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkEq("ovf cleared", longint'(ovf), 0);

        // clear, halt, evt[0] and a read all in the same cycle
        en = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            evt[0] = 1'b1;
            tick();
        end
        clear = 1'b1; halt = 1'b1; rd_req = 1'b1; rd_sel = SEL_W'(1);
        tick();
        clear = 1'b0; halt = 1'b0; rd_req = 1'b0; evt = '0; en = 1'b0;
        checkEq("clr+halt rd pre-clear", longint'(rd_data), 3);
        checkEq("clr+halt frozen", longint'(frozen), 0);
        checkEq("clr+halt done", longint'(done), 0);
        checkEq("clr+halt ovf", longint'(ovf), 0);
        tick();
        checkEq("clr+halt no done", longint'(done), 0);
        readLit(1, 0, 1'b0, "rd evt0 after clr+halt");
        tick();
        tick();
        readLit(0, 0, 1'b0, "rd cycles idle");

        // Reset while a read is in flight in COUNT
        en = 1'b1;
        tick();
        tick();
        tick();
        rd_req = 1'b1; rd_sel = '0;
        tick();
        rst = 1'b0; rd_req = 1'b0; en = 1'b0;
        #1;
        checkEq("rst rd_valid", longint'(rd_valid), 0);
        checkEq("rst rd_data", longint'(rd_data), 0);
        checkEq("rst frozen", longint'(frozen), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        checkEq("post-rst rd_valid", longint'(rd_valid), 0);
        readLit(0, 0, 1'b0, "rd cycles post-rst");
        readLit(1, 0, 1'b0, "rd evt0 post-rst");
        tick();
        tick();
        readLit(0, 0, 1'b0, "rd cycles post-rst idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
